decode_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline, sitting between the IF/ID register and the execute stage. It drives the register file's two read addresses, applies write-back bypass over the file's combinational read, and decodes the instruction into control bits. It detects load-use hazards and owns the ID/EX pipeline register, including bubble insertion and flush.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/decode_stage_if.sv | 56 +++++
 rtl/decode_stage_control.sv | 49 ++++
 rtl/decode_stage.sv | 112 +++++++++++
 tb/tb_decode_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared MIPS opcode constants, control bundle and ID/EX record.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    typedef enum logic [0:0] {
        RD_FROM_RT = 1'b0,
        RD_FROM_RD = 1'b1
    } rd_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        ctrl_t       ctrl;
    } id_ex_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Purpose  : IF/ID, register-file, write-back and ID/EX signals of decode.
// Revision : 1.0
// ============================================================================
interface decode_stage_if;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        flush;
    logic [4:0]  rf_addr_a;
    logic [4:0]  rf_addr_b;
    logic [31:0] rf_bus_a;
    logic [31:0] rf_bus_b;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc4;
    logic [31:0] id_ex_rs_val;
    logic [31:0] id_ex_rt_val;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [5:0]  id_ex_funct;
    logic        id_ex_alu_src;
    logic        id_ex_reg_write;
    logic        id_ex_mem_read;
    logic        id_ex_mem_write;
    logic        id_ex_branch;
    logic [15:0] stall_count;

    modport slave (
        input  if_valid, if_instr, if_pc4, flush, rf_bus_a, rf_bus_b,
               wb_write, wb_addr, wb_data,
        output rf_addr_a, rf_addr_b, stall, id_ex_valid, id_ex_pc4,
               id_ex_rs_val, id_ex_rt_val, id_ex_imm, id_ex_rs, id_ex_rt,
               id_ex_rd, id_ex_funct, id_ex_alu_src, id_ex_reg_write,
               id_ex_mem_read, id_ex_mem_write, id_ex_branch, stall_count
    );

    modport master (
        output if_valid, if_instr, if_pc4, flush, rf_bus_a, rf_bus_b,
               wb_write, wb_addr, wb_data,
        input  rf_addr_a, rf_addr_b, stall, id_ex_valid, id_ex_pc4,
               id_ex_rs_val, id_ex_rt_val, id_ex_imm, id_ex_rs, id_ex_rt,
               id_ex_rd, id_ex_funct, id_ex_alu_src, id_ex_reg_write,
               id_ex_mem_read, id_ex_mem_write, id_ex_branch, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_control.sv
`default_nettype none
// ============================================================================
// Module   : control_decode
// Purpose  : Opcode to control bits, destination select and rt-use flag.
// Revision : 1.0
// ============================================================================
module control_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o,
    output rd_sel_e    rd_sel_o,
    output logic       rt_is_src_o
);

    always_comb begin
        ctrl_o      = CTRL_NONE;
        rd_sel_o    = RD_FROM_RT;
        rt_is_src_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                rd_sel_o         = RD_FROM_RD;
                rt_is_src_o      = 1'b1;
            end
            OP_LW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                rt_is_src_o      = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch    = 1'b1;
                rt_is_src_o      = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : MIPS ID stage: WB bypass, decode, load-use stall, ID/EX register.
// Revision : 1.0
// ============================================================================
module decode_stage
    import mips_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    decode_stage_if.slave bus
);

    logic [31:0] instr;
    ctrl_t       dec_ctrl;
    rd_sel_e     dec_rd_sel;
    logic        dec_rt_is_src;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hazard;
    logic        stall;
    id_ex_t      id_ex_d;
    id_ex_t      id_ex_q;
    logic [15:0] stall_count_d;
    logic [15:0] stall_count_q;

    assign instr = bus.if_instr;

    control_decode u_control_decode (
        .opcode_i    (instr[31:26]),
        .ctrl_o      (dec_ctrl),
        .rd_sel_o    (dec_rd_sel),
        .rt_is_src_o (dec_rt_is_src)
    );

    assign bus.rf_addr_a = instr[25:21];
    assign bus.rf_addr_b = instr[20:16];

    // Write-first: a same-cycle WB to the read register overrides the file.
    function automatic logic [31:0] bypass(input logic [4:0]  addr,
                                           input logic [31:0] rf_data,
                                           input logic        wb_we,
                                           input logic [4:0]  wb_a,
                                           input logic [31:0] wb_d);
        if (addr == REG_ZERO)
            return '0;
        if (wb_we && (wb_a == addr))
            return wb_d;
        return rf_data;
    endfunction

    assign operand_a = bypass(instr[25:21], bus.rf_bus_a, bus.wb_write, bus.wb_addr, bus.wb_data);
    assign operand_b = bypass(instr[20:16], bus.rf_bus_b, bus.wb_write, bus.wb_addr, bus.wb_data);

    assign hazard = id_ex_q.valid && id_ex_q.ctrl.mem_read
                 && (id_ex_q.rd != REG_ZERO) && bus.if_valid
                 && ((id_ex_q.rd == instr[25:21])
                     || (dec_rt_is_src && (id_ex_q.rd == instr[20:16])));
    assign stall  = hazard && !bus.flush;

    always_comb begin
        id_ex_d = id_ex_q;
        if (bus.flush || stall) begin
            id_ex_d.valid = 1'b0;
            id_ex_d.ctrl  = CTRL_NONE;
        end else begin
            id_ex_d.valid  = bus.if_valid;
            id_ex_d.pc4    = bus.if_pc4;
            id_ex_d.rs_val = operand_a;
            id_ex_d.rt_val = operand_b;
            id_ex_d.imm    = sign_ext16(instr[15:0]);
            id_ex_d.rs     = instr[25:21];
            id_ex_d.rt     = instr[20:16];
            id_ex_d.rd     = (dec_rd_sel == RD_FROM_RD) ? instr[15:11] : instr[20:16];
            id_ex_d.funct  = instr[5:0];
            id_ex_d.ctrl   = dec_ctrl;
        end
    end

    assign stall_count_d = (stall && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                                  : stall_count_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            id_ex_q       <= '0;
            stall_count_q <= '0;
        end else begin
            id_ex_q       <= id_ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall           = stall;
    assign bus.id_ex_valid     = id_ex_q.valid;
    assign bus.id_ex_pc4       = id_ex_q.pc4;
    assign bus.id_ex_rs_val    = id_ex_q.rs_val;
    assign bus.id_ex_rt_val    = id_ex_q.rt_val;
    assign bus.id_ex_imm       = id_ex_q.imm;
    assign bus.id_ex_rs        = id_ex_q.rs;
    assign bus.id_ex_rt        = id_ex_q.rt;
    assign bus.id_ex_rd        = id_ex_q.rd;
    assign bus.id_ex_funct     = id_ex_q.funct;
    assign bus.id_ex_alu_src   = id_ex_q.ctrl.alu_src;
    assign bus.id_ex_reg_write = id_ex_q.ctrl.reg_write;
    assign bus.id_ex_mem_read  = id_ex_q.ctrl.mem_read;
    assign bus.id_ex_mem_write = id_ex_q.ctrl.mem_write;
    assign bus.id_ex_branch    = id_ex_q.ctrl.branch;
    assign bus.stall_count     = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed and randomized checks of decode_stage against a model.
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    decode_stage_if dif ();

    decode_stage dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (dif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected ID/EX contents; ctrl = {alu_src, reg_write, mem_read, mem_write, branch}
    logic        m_valid;
    logic [31:0] m_pc4, m_rs_val, m_rt_val, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [5:0]  m_funct;
    logic [4:0]  m_ctrl;
    int          m_cnt;
    logic        obs_stall;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 5'b01000;
            6'h23:   return 5'b11100;
            6'h2B:   return 5'b10010;
            6'h04:   return 5'b00001;
            6'h08:   return 5'b11000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'h0;
        if (dif.wb_write && dif.wb_addr == a) return dif.wb_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        logic [5:0] op;
        logic       reads_rt;
        op       = dif.if_instr[31:26];
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return m_valid && m_ctrl[2] && (m_rd != 0) && dif.if_valid &&
               ((m_rd == dif.if_instr[25:21]) || (reads_rt && m_rd == dif.if_instr[20:16]));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc4 = 0; m_rs_val = 0; m_rt_val = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_funct = 0; m_ctrl = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic stl);
        logic [31:0] ins;
        ins = dif.if_instr;
        if (stl && m_cnt < 65535) m_cnt++;
        if (dif.flush || stl) begin
            m_valid = 0;
            m_ctrl  = 0;
        end else begin
            m_valid  = dif.if_valid;
            m_pc4    = dif.if_pc4;
            m_rs_val = ref_operand(ins[25:21], dif.rf_bus_a);
            m_rt_val = ref_operand(ins[20:16], dif.rf_bus_b);
            m_imm    = 32'($signed(ins[15:0]));
            m_rs     = ins[25:21];
            m_rt     = ins[20:16];
            m_rd     = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
            m_funct  = ins[5:0];
            m_ctrl   = ref_ctrl(ins[31:26]);
        end
    endtask

    task automatic check_regs();
        check_val("valid", 32'(dif.id_ex_valid), 32'(m_valid));
        check_val("ctrl", 32'({dif.id_ex_alu_src, dif.id_ex_reg_write, dif.id_ex_mem_read,
                               dif.id_ex_mem_write, dif.id_ex_branch}), 32'(m_ctrl));
        check_val("stall_count", 32'(dif.stall_count), m_cnt[31:0]);
        if (m_valid) begin
            check_val("pc4", dif.id_ex_pc4, m_pc4);
            check_val("rs_val", dif.id_ex_rs_val, m_rs_val);
            check_val("rt_val", dif.id_ex_rt_val, m_rt_val);
            check_val("imm", dif.id_ex_imm, m_imm);
            check_val("rs", 32'(dif.id_ex_rs), 32'(m_rs));
            check_val("rt", 32'(dif.id_ex_rt), 32'(m_rt));
            check_val("funct", 32'(dif.id_ex_funct), 32'(m_funct));
            if (m_ctrl[3]) check_val("rd", 32'(dif.id_ex_rd), 32'(m_rd));
        end
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic cycle();
        logic exp_stall;
        #1;
        check_val("rf_addr_a", 32'(dif.rf_addr_a), 32'(dif.if_instr[25:21]));
        check_val("rf_addr_b", 32'(dif.rf_addr_b), 32'(dif.if_instr[20:16]));
        exp_stall = ref_hazard() && !dif.flush;
        obs_stall = dif.stall;
        check_val("stall", 32'(obs_stall), 32'(exp_stall));
        model_step(exp_stall);
        @(posedge CLK);
        #1;
        check_regs();
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
        dif.if_valid = v;
        dif.if_instr = ins;
        dif.if_pc4   = $urandom;
        dif.flush    = fl;
        dif.rf_bus_a = $urandom;
        dif.rf_bus_b = $urandom;
        dif.wb_write = 1'b0;
        dif.wb_addr  = 5'd0;
        dif.wb_data  = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_outs"}, 32'({dif.id_ex_valid, dif.id_ex_alu_src, dif.id_ex_reg_write,
                   dif.id_ex_mem_read, dif.id_ex_mem_write, dif.id_ex_branch, dif.stall}), 32'h0);
        check_val({tag, "_data"}, dif.id_ex_pc4 | dif.id_ex_rs_val | dif.id_ex_rt_val | dif.id_ex_imm, 32'h0);
        check_val({tag, "_addr"}, 32'({dif.id_ex_rs, dif.id_ex_rt, dif.id_ex_rd, dif.id_ex_funct}), 32'h0);
        check_val({tag, "_cnt"}, 32'(dif.stall_count), 32'h0);
    endtask

    localparam logic [31:0] LW_2_0_1   = {6'h23, 5'd1, 5'd2, 16'd0};
    localparam logic [31:0] ADD_4_2_3  = {6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20};

    initial begin
        logic [5:0]  op;
        logic [15:0] low;
        logic [31:0] ins;
        model_reset();
        drive(1'b0, 32'h0, 1'b0);
        #2;
        check_all_zero("reset_init");
        @(negedge CLK);
        RST_N = 1'b1;

        // Bypass: add $3,$5,$0 with WB writing $5
        drive(1'b1, {6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20}, 1'b0);
        dif.rf_bus_a = 32'h11;
        dif.wb_write = 1'b1; dif.wb_addr = 5'd5; dif.wb_data = 32'hDEADBEEF;
        cycle();
        check_val("bypass_rs", dif.id_ex_rs_val, 32'hDEADBEEF);
        check_val("bypass_rt", dif.id_ex_rt_val, 32'h0);

        // Load-use: exactly one stall and one bubble
        drive(1'b1, LW_2_0_1, 1'b0);
        cycle();
        drive(1'b1, ADD_4_2_3, 1'b0);
        cycle();
        check_val("lu_stall", 32'(obs_stall), 32'h1);
        check_val("lu_bubble", 32'(dif.id_ex_valid), 32'h0);
        cycle();
        check_val("lu_stall2", 32'(obs_stall), 32'h0);
        check_val("lu_add_in", 32'({dif.id_ex_valid, dif.id_ex_rd}), 32'({1'b1, 5'd4}));
        check_val("lu_count", 32'(dif.stall_count), 32'h1);

        // No false hazards
        drive(1'b1, LW_2_0_1, 1'b0);
        cycle();
        drive(1'b1, {6'h08, 5'd7, 5'd2, 16'd4}, 1'b0);
        cycle();
        check_val("addi_nostall", 32'(obs_stall), 32'h0);
        drive(1'b1, {6'h23, 5'd1, 5'd0, 16'd0}, 1'b0);
        cycle();
        drive(1'b1, {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20}, 1'b0);
        cycle();
        check_val("lw0_nostall", 32'(obs_stall), 32'h0);

        // Flush beats a hazard
        drive(1'b1, LW_2_0_1, 1'b0);
        cycle();
        drive(1'b1, ADD_4_2_3, 1'b1);
        cycle();
        check_val("flush_stall", 32'(obs_stall), 32'h0);
        check_val("flush_valid", 32'(dif.id_ex_valid), 32'h0);
        check_val("flush_count", 32'(dif.stall_count), 32'h1);

        // Decode of sw and a negative addi immediate
        drive(1'b1, {6'h2B, 5'd1, 5'd6, 16'd8}, 1'b0);
        cycle();
        check_val("sw_ctrl", 32'({dif.id_ex_mem_write, dif.id_ex_reg_write}), 32'h2);
        check_val("sw_imm", dif.id_ex_imm, 32'h00000008);
        drive(1'b1, {6'h08, 5'd3, 5'd9, 16'hFFFC}, 1'b0);
        cycle();
        check_val("addi_imm", dif.id_ex_imm, 32'hFFFFFFFC);

        // Asynchronous reset in the middle of a stall
        drive(1'b1, LW_2_0_1, 1'b0);
        cycle();
        drive(1'b1, ADD_4_2_3, 1'b0);
        #1;
        check_val("pre_rst_stall", 32'(dif.stall), 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("reset_mid");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;

        // Randomized traffic with small register numbers to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h08;
                default: op = 6'($urandom);
            endcase
            low = 16'($urandom);
            low[15:11] = 5'($urandom_range(0, 7));
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), low};
            drive($urandom_range(0, 9) != 0, ins, $urandom_range(0, 9) == 0);
            dif.wb_write = 1'($urandom);
            dif.wb_addr  = 5'($urandom_range(0, 7));
            dif.wb_data  = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
